control_unit: RTL and testbench

Multicycle sequencer for the accumulator CPU. It steps the fetch/decode/execute loop, drives the instruction register load strobe and the program-counter controls, handshakes with instruction/data memory, and issues ALU and accumulator write-enable commands. It decodes the 6-bit opcode held in the instruction register and flags halt, illegal opcode and, optionally, memory timeout.

---
 rtl/cpu_pkg.sv | 45 ++++
 rtl/cu_timeout.sv | 33 +++
 rtl/control_unit.sv | 144 ++++++++++++++
 tb/tb_control_unit.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcodes, ALU selects, sequencer
// state encoding and the wait-counter width.
package cpu_pkg;

  localparam int OPCODE_W = 6;
  localparam int TMO_CNT_W = 8;

  localparam logic [OPCODE_W-1:0] OP_NOP   = 6'd0;
  localparam logic [OPCODE_W-1:0] OP_LOAD  = 6'd1;
  localparam logic [OPCODE_W-1:0] OP_STORE = 6'd2;
  localparam logic [OPCODE_W-1:0] OP_ADD   = 6'd3;
  localparam logic [OPCODE_W-1:0] OP_SUB   = 6'd4;
  localparam logic [OPCODE_W-1:0] OP_AND   = 6'd5;
  localparam logic [OPCODE_W-1:0] OP_OR    = 6'd6;
  localparam logic [OPCODE_W-1:0] OP_JMP   = 6'd7;
  localparam logic [OPCODE_W-1:0] OP_BRZ   = 6'd8;
  localparam logic [OPCODE_W-1:0] OP_HALT  = 6'd63;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_OR   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_HALT   = 3'd5,
    ST_ERR    = 3'd6
  } state_e;

  function automatic logic [2:0] alu_sel(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_ADD:  alu_sel = ALU_ADD;
      OP_SUB:  alu_sel = ALU_SUB;
      OP_AND:  alu_sel = ALU_AND;
      OP_OR:   alu_sel = ALU_OR;
      default: alu_sel = ALU_PASS;
    endcase
  endfunction

endpackage

// File: rtl/cu_timeout.sv
// Memory wait counter: flags the cycle in which the LIMIT-th consecutive
// un-acknowledged request cycle occurs. An ack in that cycle suppresses it.
module cu_timeout
  import cpu_pkg::*;
#(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic waiting_i,
  input  logic ack_i,
  output logic expired_o
);

  localparam logic [TMO_CNT_W-1:0] LAST = TMO_CNT_W'(LIMIT - 1);

  logic [TMO_CNT_W-1:0] cnt_q, cnt_d;

  // Any cycle that is not an unanswered wait clears the count, so each
  // FETCH/MEM visit starts from zero.
  always_comb begin
    cnt_d = '0;
    if (waiting_i && !ack_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired_o = waiting_i && !ack_i && (cnt_q == LAST);

endmodule

// File: rtl/control_unit.sv
// Multicycle fetch/decode/execute sequencer for the accumulator CPU.
// Optional memory timeout is built when CU_TIMEOUT_EN is defined.
module control_unit
  import cpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero_flag,
  input  logic                mem_ack,
  output logic                mem_req,
  output logic                mem_we,
  output logic                addr_sel,
  output logic                ld_ir,
  output logic                pc_inc,
  output logic                pc_ld,
  output logic [2:0]          alu_op,
  output logic                acc_we,
  output logic                halted,
  output logic                illegal,
  output logic                bus_err,
  output logic [2:0]          state
);

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   timeout;
  state_e next_st;

  // Handshake: mem_req rises on entry to FETCH/MEM and stays high until and
  // including the cycle mem_ack is seen; mem_ack in any other state is ignored.
  assign next_st = run ? ST_FETCH : ST_IDLE;

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ld_ir     = 1'b0;
    pc_inc    = 1'b0;
    pc_ld     = 1'b0;
    alu_op    = ALU_PASS;
    acc_we    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ld_ir   = 1'b1;
          pc_inc  = 1'b1;
          state_d = ST_DECODE;
        end else if (timeout) begin
          state_d = ST_ERR;
        end
      end
      ST_DECODE: begin
        case (opcode)
          OP_NOP:                         state_d = next_st;
          OP_ADD, OP_SUB, OP_AND, OP_OR:  state_d = ST_EXEC;
          OP_LOAD, OP_STORE:              state_d = ST_MEM;
          OP_JMP: begin
            pc_ld   = 1'b1;
            state_d = next_st;
          end
          OP_BRZ: begin
            pc_ld   = zero_flag;
            state_d = next_st;
          end
          OP_HALT:                        state_d = ST_HALT;
          default: begin
            illegal_d = 1'b1;
            state_d   = ST_ERR;
          end
        endcase
      end
      ST_EXEC: begin
        alu_op  = alu_sel(opcode);
        acc_we  = 1'b1;
        state_d = next_st;
      end
      ST_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (opcode == OP_STORE);
        if (mem_ack) begin
          acc_we  = (opcode == OP_LOAD);
          state_d = next_st;
        end else if (timeout) begin
          state_d = ST_ERR;
        end
      end
      default: ;  // HALT and ERR hold until reset
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

`ifdef CU_TIMEOUT_EN
  logic waiting;
  logic bus_err_q;

  assign waiting = (state_q == ST_FETCH) || (state_q == ST_MEM);

  cu_timeout #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .waiting_i (waiting),
    .ack_i     (mem_ack),
    .expired_o (timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       bus_err_q <= 1'b0;
    else if (timeout) bus_err_q <= 1'b1;
  end

  assign bus_err = bus_err_q;
`else
  // Legal limits are 1..255, so without the counter this is constant 0.
  assign timeout = (TIMEOUT_CYCLES == 0);
  assign bus_err = 1'b0;
`endif

  assign halted  = (state_q == ST_HALT);
  assign illegal = illegal_q;
  assign state   = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: each driven cycle pushes its expected
// output vector; a negedge monitor pops and compares.
module tb_control_unit;

  localparam int W = 16;
  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2,
                         S_EXEC = 3'd3, S_MEM = 3'd4, S_HALT = 3'd5, S_ERR = 3'd6;
  // strobe mask: {mem_req, mem_we, addr_sel, ld_ir, pc_inc, pc_ld}
  localparam logic [5:0] NONE = 6'b000000, REQ = 6'b100000, WE = 6'b010000,
                         ASEL = 6'b001000, LDIR = 6'b000100, PCINC = 6'b000010,
                         PCLD = 6'b000001;
  // flag mask: {acc_we, halted, illegal, bus_err}
  localparam logic [3:0] NOF = 4'b0000, ACCWE = 4'b1000, HLT = 4'b0100,
                         ILL = 4'b0010, BUS = 4'b0001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       zero_flag = 1'b0;
  logic       mem_ack = 1'b0;
  logic       mem_req, mem_we, addr_sel, ld_ir, pc_inc, pc_ld;
  logic [2:0] alu_op;
  logic       acc_we, halted, illegal, bus_err;
  logic [2:0] state;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;

`ifdef CU_TIMEOUT_EN
  control_unit #(.TIMEOUT_CYCLES(4)) dut (
`else
  control_unit dut (
`endif
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .zero_flag(zero_flag),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
    .ld_ir(ld_ir), .pc_inc(pc_inc), .pc_ld(pc_ld), .alu_op(alu_op),
    .acc_we(acc_we), .halted(halted), .illegal(illegal), .bus_err(bus_err),
    .state(state)
  );

  // clock/reset block
  always #5 clk = ~clk;

  function automatic logic [W-1:0] ev(input logic [2:0] st, input logic [5:0] strb,
                                      input logic [2:0] aop, input logic [3:0] flg);
    return {st, strb, aop, flg};
  endfunction

  // monitor / scoreboard
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] exp_v, act_v;
      string        nm;
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      act_v = {state, mem_req, mem_we, addr_sel, ld_ir, pc_inc, pc_ld,
               alu_op, acc_we, halted, illegal, bus_err};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL %s: got %h expected %h (state/strobes/alu/flags)", nm, act_v, exp_v);
      end
    end
  end

  // driver: apply inputs for one cycle and queue the outputs expected in it
  task automatic cyc(input logic r, input logic [5:0] op, input logic z,
                     input logic a, input logic [W-1:0] e, input string nm);
    run = r; opcode = op; zero_flag = z; mem_ack = a;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk); #1;
    // reset with run high and a stray ack
    cyc(1, 6'd3, 0, 1, ev(S_IDLE, NONE, 0, NOF), "reset_outputs");
    rst_n = 1'b1;
    cyc(1, 6'd3, 0, 0, ev(S_IDLE, NONE, 0, NOF), "idle_after_release");
    // zero-wait ADD; ack during DECODE must be ignored
    cyc(1, 6'd3, 0, 1, ev(S_FETCH, REQ | LDIR | PCINC, 0, NOF), "add_fetch_ack");
    cyc(1, 6'd3, 0, 1, ev(S_DECODE, NONE, 0, NOF), "add_decode");
    cyc(1, 6'd3, 0, 0, ev(S_EXEC, NONE, 3'd1, ACCWE), "add_exec");
    // LOAD with 3 wait cycles
    cyc(1, 6'd1, 0, 1, ev(S_FETCH, REQ | LDIR | PCINC, 0, NOF), "load_fetch");
    cyc(1, 6'd1, 0, 0, ev(S_DECODE, NONE, 0, NOF), "load_decode");
    for (int i = 0; i < 3; i++)
      cyc(1, 6'd1, 0, 0, ev(S_MEM, REQ | ASEL, 0, NOF), "load_wait");
    cyc(1, 6'd1, 0, 1, ev(S_MEM, REQ | ASEL, 0, ACCWE), "load_ack");
    // zero-wait STORE
    cyc(1, 6'd2, 0, 1, ev(S_FETCH, REQ | LDIR | PCINC, 0, NOF), "store_fetch");
    cyc(1, 6'd2, 0, 0, ev(S_DECODE, NONE, 0, NOF), "store_decode");
    cyc(1, 6'd2, 0, 1, ev(S_MEM, REQ | WE | ASEL, 0, NOF), "store_ack");
    // branches
    cyc(1, 6'd8, 1, 1, ev(S_FETCH, REQ | LDIR | PCINC, 0, NOF), "brz1_fetch");
    cyc(1, 6'd8, 1, 0, ev(S_DECODE, PCLD, 0, NOF), "brz_taken");
    cyc(1, 6'd8, 0, 1, ev(S_FETCH, REQ | LDIR | PCINC, 0, NOF), "brz0_fetch");
    cyc(1, 6'd8, 0, 0, ev(S_DECODE, NONE, 0, NOF), "brz_not_taken");
    cyc(1, 6'd7, 0, 1, ev(S_FETCH, REQ | LDIR | PCINC, 0, NOF), "jmp_fetch");
    cyc(1, 6'd7, 0, 0, ev(S_DECODE, PCLD, 0, NOF), "jmp_decode");
    cyc(1, 6'd0, 0, 1, ev(S_FETCH, REQ | LDIR | PCINC, 0, NOF), "nop_fetch");
    cyc(1, 6'd0, 0, 0, ev(S_DECODE, NONE, 0, NOF), "nop_decode");
    // SUB with run dropped mid-instruction
    cyc(1, 6'd4, 0, 1, ev(S_FETCH, REQ | LDIR | PCINC, 0, NOF), "sub_fetch");
    cyc(0, 6'd4, 0, 0, ev(S_DECODE, NONE, 0, NOF), "sub_decode_run0");
    cyc(0, 6'd4, 0, 0, ev(S_EXEC, NONE, 3'd2, ACCWE), "sub_exec_run0");
    cyc(0, 6'd4, 0, 1, ev(S_IDLE, NONE, 0, NOF), "idle_after_run0");
    cyc(1, 6'd4, 0, 0, ev(S_IDLE, NONE, 0, NOF), "idle_run1");
    // async reset in the middle of a MEM wait
    cyc(1, 6'd1, 0, 1, ev(S_FETCH, REQ | LDIR | PCINC, 0, NOF), "rst_fetch");
    cyc(1, 6'd1, 0, 0, ev(S_DECODE, NONE, 0, NOF), "rst_decode");
    cyc(1, 6'd1, 0, 0, ev(S_MEM, REQ | ASEL, 0, NOF), "rst_mem_wait");
    rst_n = 1'b0;
    cyc(1, 6'd1, 0, 0, ev(S_IDLE, NONE, 0, NOF), "reset_mid_mem");
    rst_n = 1'b1;
    cyc(1, 6'd1, 0, 0, ev(S_IDLE, NONE, 0, NOF), "idle_after_rst2");
    // illegal opcode 6'b011110
    cyc(1, 6'd30, 0, 1, ev(S_FETCH, REQ | LDIR | PCINC, 0, NOF), "ill_fetch");
    cyc(1, 6'd30, 0, 0, ev(S_DECODE, NONE, 0, NOF), "ill_decode");
    cyc(1, 6'd30, 1, 1, ev(S_ERR, NONE, 0, ILL), "ill_err");
    cyc(1, 6'd3, 1, 1, ev(S_ERR, NONE, 0, ILL), "ill_err_stays");
    rst_n = 1'b0;
    cyc(1, 6'd3, 0, 0, ev(S_IDLE, NONE, 0, NOF), "ill_cleared");
    rst_n = 1'b1;
    cyc(1, 6'd63, 0, 0, ev(S_IDLE, NONE, 0, NOF), "halt_idle");
    // HALT
    cyc(1, 6'd63, 0, 1, ev(S_FETCH, REQ | LDIR | PCINC, 0, NOF), "halt_fetch");
    cyc(1, 6'd63, 0, 0, ev(S_DECODE, NONE, 0, NOF), "halt_decode");
    cyc(1, 6'd63, 0, 1, ev(S_HALT, NONE, 0, HLT), "halted");
    cyc(0, 6'd63, 0, 1, ev(S_HALT, NONE, 0, HLT), "halted_stays");
`ifdef CU_TIMEOUT_EN
    rst_n = 1'b0;
    cyc(1, 6'd0, 0, 0, ev(S_IDLE, NONE, 0, NOF), "tmo_reset");
    rst_n = 1'b1;
    cyc(1, 6'd0, 0, 0, ev(S_IDLE, NONE, 0, NOF), "tmo_idle");
    for (int i = 0; i < 4; i++)
      cyc(1, 6'd0, 0, 0, ev(S_FETCH, REQ, 0, NOF), "tmo_wait");
    cyc(1, 6'd0, 0, 1, ev(S_ERR, NONE, 0, BUS), "tmo_bus_err");
    rst_n = 1'b0;
    cyc(1, 6'd0, 0, 0, ev(S_IDLE, NONE, 0, NOF), "tmo_reset2");
    rst_n = 1'b1;
    cyc(1, 6'd0, 0, 0, ev(S_IDLE, NONE, 0, NOF), "tmo_idle2");
    for (int i = 0; i < 3; i++)
      cyc(1, 6'd0, 0, 0, ev(S_FETCH, REQ, 0, NOF), "tmo_wait2");
    cyc(1, 6'd0, 0, 1, ev(S_FETCH, REQ | LDIR | PCINC, 0, NOF), "tmo_ack_wins");
    cyc(1, 6'd0, 0, 0, ev(S_DECODE, NONE, 0, NOF), "tmo_decode");
    cyc(1, 6'd0, 0, 0, ev(S_FETCH, REQ, 0, NOF), "tmo_refetch");
`endif
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
